// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory wait freeze, timeout trap.
// Latency: enables/flushes/dmem_req are combinational from inputs and state; state and counters update on the next rising edge.
// Backpressure: dmem_ready low freezes IF/ID/EX/MEM and bubbles WB; no ready after TIMEOUT wait cycles parks the FSM in ERR until reset.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_rs1/2, id_rs1/2_use         ID-stage source registers and their use flags
//   ex_rd, ex_read_en              EX destination register, EX is a load
//   ex_branch_taken                EX resolved a taken branch/jump
//   mem_read_en, dmem_ready        load in MEM, data memory read data valid
//   *_en, *_flush                  stage register load enables / bubble inserts
//   dmem_req                       data memory read request
//   timeout_err, stall_cnt         sticky timeout flag, saturating pc_en=0 cycle count
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [4:0]       ex_rd,
  input  logic             ex_read_en,
  input  logic             ex_branch_taken,
  input  logic             mem_read_en,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             dmem_req,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // wait_q counts MWAIT cycles already spent with dmem_ready low, 0..TIMEOUT-1
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic load_use;
  logic mem_stall;
  logic in_err;

  // ex_rd==0 is the hard-wired zero register and never creates a dependency
  assign load_use = ex_read_en && (ex_rd != 5'd0) &&
                    ((id_rs1_use && (id_rs1 == ex_rd)) ||
                     (id_rs2_use && (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    timeout_err_d = timeout_err_q;
    mem_stall     = 1'b0;
    in_err        = 1'b0;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_flush   = 1'b0;
    dmem_req      = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = mem_read_en;
        if (mem_read_en && !dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = MWAIT;
          wait_d    = '0;
        end
      end
      MWAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          mem_stall = 1'b1;
          if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            state_d       = ERR;
            timeout_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          // release cycle: falls through to the normal branch/load-use rules
          state_d = RUN;
        end
      end
      default: in_err = 1'b1;
    endcase

    if (in_err) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      // a taken branch stays in the frozen EX stage and flushes on release
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // hold PC and IF/ID one cycle; the bubble in EX clears the hazard
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end

    // everything quiet while reset is held
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      dmem_req    = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_q        <= '0;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by randomized traffic.
// Expected outputs come from a behavioural model and are queued per cycle.
// A separate monitor pops and compares once outputs have settled each cycle.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_rs1_use = 1'b0, id_rs2_use = 1'b0;
  logic ex_read_en = 1'b0, ex_branch_taken = 1'b0, mem_read_en = 1'b0, dmem_ready = 1'b1;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, dmem_req, timeout_err;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd(ex_rd), .ex_read_en(ex_read_en), .ex_branch_taken(ex_branch_taken),
    .mem_read_en(mem_read_en), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .dmem_req(dmem_req), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [9:0]    ctl;  // pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,memwb_fl,dmem_req,timeout_err
    logic [CW-1:0] sc;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pipeline situation in plain terms
  bit m_dead    = 1'b0;  // trapped after a memory timeout
  bit m_waiting = 1'b0;  // a stalled load has been waiting at least one cycle
  int m_waited  = 0;     // how many waiting cycles have passed without data
  int m_stalls  = 0;     // cycles the PC has been held since reset

  task automatic step(input bit r, input int a1, input int a2, input bit u1, input bit u2,
                      input int rd, input bit lre, input bit br, input bit mre, input bit rdy);
    exp_t e;
    bit pc, ifid, idex, exmem, memwb, f1, f2, f3, req, terr, stalled;
    @(negedge clk);
    rst_n = r; id_rs1 = a1[4:0]; id_rs2 = a2[4:0]; id_rs1_use = u1; id_rs2_use = u2;
    ex_rd = rd[4:0]; ex_read_en = lre; ex_branch_taken = br; mem_read_en = mre; dmem_ready = rdy;
    {pc, ifid, idex, exmem, memwb, f1, f2, f3, req} = 9'b111110000;
    terr = m_dead;
    e.sc = m_stalls[CW-1:0];
    if (!r) begin
      {pc, ifid, idex, exmem, memwb} = 5'b0;
      terr = 1'b0; e.sc = '0;
      m_dead = 1'b0; m_waiting = 1'b0; m_waited = 0; m_stalls = 0;
    end else begin
      if (m_dead) begin
        {pc, ifid, idex, exmem, memwb} = 5'b0;
      end else begin
        stalled = m_waiting ? !rdy : (mre && !rdy);
        req = m_waiting ? 1'b1 : mre;
        if (stalled) begin
          {pc, ifid, idex, exmem} = 4'b0;
          f3 = 1'b1;
          if (!m_waiting) begin
            m_waiting = 1'b1; m_waited = 0;
          end else begin
            m_waited++;
            if (m_waited == TO) begin m_dead = 1'b1; m_waiting = 1'b0; end
          end
        end else begin
          m_waiting = 1'b0;
          if (br) begin
            f1 = 1'b1; f2 = 1'b1;
          end else if (lre && rd != 0 && ((u1 && a1 == rd) || (u2 && a2 == rd))) begin
            pc = 1'b0; ifid = 1'b0; f2 = 1'b1;
          end
        end
      end
      if (!pc && m_stalls < (1 << CW) - 1) m_stalls++;
    end
    e.ctl = {pc, ifid, idex, exmem, memwb, f1, f2, f3, req, terr};
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 2, 0, 0, 3, 0, 0, 0, 1);
  endtask

  // Monitor: outputs settle 2 time units after the negedge where inputs change
  initial begin
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, memwb_flush, dmem_req, timeout_err};
        n_cmp++;
        if (got !== e.ctl || stall_cnt !== e.sc) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t got ctl=%b stall_cnt=%0d, want ctl=%b stall_cnt=%0d",
                   $time, got, stall_cnt, e.ctl, e.sc);
        end
      end
    end
  end

  initial begin
    int pct;
    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 5, 5, 1, 1, 5, 1, 1, 1, 0);
    idle(2);
    // load-use on rs1, then on rs2, then ex_rd==0 (no stall)
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 1);
    idle(1);
    step(1, 0, 7, 0, 1, 7, 1, 0, 0, 1);
    step(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
    step(1, 5, 0, 0, 0, 5, 1, 0, 0, 1);
    // branch beats load-use
    step(1, 5, 0, 1, 0, 5, 1, 1, 0, 1);
    // memory wait: 3 low then ready
    for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0, 3, 0, 0, 1, 0);
    step(1, 1, 2, 0, 0, 3, 0, 0, 1, 1);
    idle(1);
    // branch inside memory stall, flush on release
    for (int i = 0; i < 2; i++) step(1, 1, 2, 0, 0, 3, 0, 1, 1, 0);
    step(1, 1, 2, 0, 0, 3, 0, 1, 1, 1);
    idle(1);
    // ready arrives on the timeout cycle: back to RUN
    for (int i = 0; i < TO; i++) step(1, 1, 2, 0, 0, 3, 0, 0, 1, 0);
    step(1, 1, 2, 0, 0, 3, 0, 0, 1, 1);
    idle(2);
    // timeout into ERR, dwell long enough to saturate stall_cnt, then reset
    for (int i = 0; i < TO + 1; i++) step(1, 1, 2, 0, 0, 3, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++) step(1, 5, 0, 1, 0, 5, 1, 1, 1, 1);
    step(0, 1, 2, 0, 0, 3, 0, 0, 0, 1);
    idle(2);
    // reset asserted mid-MWAIT
    for (int i = 0; i < 2; i++) step(1, 1, 2, 0, 0, 3, 0, 0, 1, 0);
    step(0, 1, 2, 0, 0, 3, 0, 0, 1, 0);
    idle(2);
    // randomized traffic with varying memory responsiveness
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 2))
        0: pct = 25;
        1: pct = 60;
        default: pct = 92;
      endcase
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) >= 2,
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 99) < pct);
      end
    end
    @(negedge clk);
    #5;
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of MWAIT cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall cycle counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  input  5 each  ID-stage source register numbers.
REQ-006 id_rs1_use, id_rs2_use  input  1 each  the ID instruction reads rs1 / rs2.
REQ-007 ex_rd  input  5  ID/EX destination register.
REQ-008 ex_read_en  input  1  the EX instruction is a load.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-010 mem_read_en  input  1  read_en_o of the EX/MEM register; a load is in MEM.
REQ-011 dmem_ready  input  1  data memory read data valid this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register load enables.
REQ-013 ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (wb_en=0, read_en=0) into that register.
REQ-014 dmem_req  output  1  data memory read request.
REQ-015 timeout_err  output  1  sticky memory-timeout flag.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0.

Function
REQ-017 SHALL implement FSM states RUN, MWAIT, ERR.
REQ-018 Default outputs SHALL be all enables=1, all flushes=0, dmem_req=0.
REQ-019 Load-use hazard SHALL be detected as: ex_read_en, and ex_rd!=0, and (id_rs1_use and id_rs1==ex_rd, or id_rs2_use and id_rs2==ex_rd).
REQ-020 Memory stall SHALL be detected as: (state==RUN, mem_read_en=1, dmem_ready=0), or state==MWAIT with dmem_ready=0.
REQ-021 In RUN or MWAIT, dmem_req SHALL equal mem_read_en in RUN and SHALL be 1 in MWAIT.
REQ-022 Priority SHALL be ERR > memory stall > branch flush > load-use.
REQ-023 During a memory stall: pc_en, ifid_en, idex_en, exmem_en=0; memwb_en=1; memwb_flush=1; no other flush.
REQ-024 Branch flush (no memory stall, ex_branch_taken=1): ifid_flush=1, idex_flush=1, all enables=1; a concurrent load-use is ignored.
REQ-025 Load-use (no higher-priority event): pc_en=0, ifid_en=0, idex_flush=1; exactly one bubble per hazard, with no state change.
REQ-026 A branch that occurs during a memory stall is held by the frozen EX stage; its flush SHALL occur in the release cycle (dmem_ready=1).
REQ-027 RUN->MWAIT SHALL occur when mem_read_en=1 and dmem_ready=0.
REQ-028 MWAIT->RUN SHALL occur on dmem_ready=1; that cycle follows the non-stall rules.
REQ-029 The wait counter SHALL clear on entering MWAIT and increment each MWAIT cycle.
REQ-030 MWAIT->ERR SHALL occur when the wait count reaches TIMEOUT with dmem_ready=0; dmem_ready in that same cycle wins, and the FSM goes to RUN.
REQ-031 ERR: all enables=0, flushes=0, dmem_req=0, timeout_err=1; the FSM SHALL leave ERR only by reset.
REQ-032 stall_cnt SHALL increment each cycle with pc_en=0 and saturate at 2^CNT_W-1.
REQ-033 ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-034 While rst_n=0: state=RUN, wait counter=0, stall_cnt=0, timeout_err=0, all enables=0, all flushes=0, dmem_req=0.
REQ-035 Reset asserted mid-MWAIT or in ERR SHALL abort immediately; the first cycle after release SHALL be RUN with default outputs.

Verification
REQ-036 Load-use: ex_read_en=1, ex_rd=5, id_rs1=5, id_rs1_use=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-037 Mem wait: mem_read_en=1, dmem_ready low 3 cycles then high -> dmem_req=1 for 4 cycles, 3 freeze cycles with memwb_flush=1, RUN after; stall_cnt=3.
REQ-038 Branch inside mem stall: ex_branch_taken=1 while dmem_ready=0 for 2 cycles -> no flush while stalled; ifid_flush=idex_flush=1 in the release cycle.
REQ-039 Timeout with TIMEOUT=4: dmem_ready held 0 -> ERR after 4 MWAIT cycles, timeout_err=1, all enables 0; rst_n pulse -> RUN, timeout_err=0.
REQ-040 ex_rd=0 with matching id_rs1=0 and ex_read_en=1 -> no stall.
REQ-041 Boundary: dmem_ready=1 on the TIMEOUT cycle -> RUN, timeout_err stays 0.
